// File: rtl/sampler_pkg.sv
// Shared types and defaults for the sampler pipeline stages.
package sampler_pkg;

    localparam int CAND_W_DEF     = 779;
    localparam int CNT_W_DEF      = 32;
    localparam int DEPTH_DEF      = 8;
    localparam int MAX_REJECT_DEF = 1024;

    // Packed candidate: var_19 at the MSB down to var_0 at the LSB.
    typedef logic [CAND_W_DEF-1:0] cand_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } acc_state_e;

endpackage

// File: rtl/sample_accept_fifo_if.sv
// Candidate input stream and sample output stream of the accept stage.
// master = the side that produces candidates and consumes samples,
// slave  = the accept stage itself.
interface sample_accept_fifo_if
    import sampler_pkg::*;
#(
    parameter int CAND_W = CAND_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [CAND_W-1:0] in_cand;
    logic              in_sat;

    logic              out_valid;
    logic              out_ready;
    logic [CAND_W-1:0] out_cand;

    modport master (
        output in_valid, in_cand, in_sat, out_ready,
        input  in_ready, out_valid, out_cand
    );

    modport slave (
        input  in_valid, in_cand, in_sat, out_ready,
        output in_ready, out_valid, out_cand
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Generic synchronous first-word-fall-through FIFO. The head entry is
// presented combinationally from storage whenever the FIFO is non-empty,
// so a word written at edge k is visible right after edge k.
module sync_fifo_fwft #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Gate the head with empty so the output reads zero after reset even
    // though the storage itself holds stale data.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately not reset; validity is
        // tracked by count, and leaving it out keeps it a plain RAM.
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sample_accept_fifo.sv
// Accept stage behind the constraint checker: consumes candidates during a
// run, queues the satisfied ones, counts attempts/accepts, ends the run on
// reaching the target or on too many consecutive rejects, then drains.
module sample_accept_fifo
    import sampler_pkg::*;
#(
    parameter int CAND_W     = CAND_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MAX_REJECT = MAX_REJECT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_samples,
    sample_accept_fifo_if.slave    bus,
    output logic [CNT_W-1:0]       attempt_cnt,
    output logic [CNT_W-1:0]       accept_cnt,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted
);

    localparam int REJ_W  = $clog2(MAX_REJECT + 1);
    localparam int FCNT_W = $clog2(DEPTH + 1);

    acc_state_e         state;
    acc_state_e         state_next;
    logic [CNT_W-1:0]   target;
    logic [REJ_W-1:0]   reject_len;

    logic               fifo_full;
    logic               fifo_empty;
    logic [FCNT_W-1:0]  fifo_count;

    logic               xfer;
    logic               push;
    logic               pop;
    logic               start_run;
    logic [CNT_W-1:0]   attempt_inc;
    logic [CNT_W-1:0]   accept_inc;
    logic               hit_target;
    logic               hit_abort;

    // Ready depends only on registered state, never on out_ready.
    assign bus.in_ready = (state == RUN) && !fifo_full;
    assign bus.out_valid = !fifo_empty;

    assign xfer      = bus.in_valid && bus.in_ready;
    assign push      = xfer && bus.in_sat;
    assign pop       = bus.out_valid && bus.out_ready;
    assign start_run = (state == IDLE) && start;

    // Counters stick at all-ones instead of wrapping.
    assign attempt_inc = (attempt_cnt == '1) ? attempt_cnt : attempt_cnt + CNT_W'(1);
    assign accept_inc  = (accept_cnt  == '1) ? accept_cnt  : accept_cnt  + CNT_W'(1);

    assign hit_target = push && (accept_inc == target);
    assign hit_abort  = xfer && !bus.in_sat &&
                        ((reject_len + REJ_W'(1)) == REJ_W'(MAX_REJECT));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    sync_fifo_fwft #(
        .DATA_W (CAND_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.in_cand),
        .pop       (pop),
        .pop_data  (bus.out_cand),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Run-control state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode for the run controller.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (num_samples == '0) ? DRAIN : RUN;
            RUN:     if (hit_target || hit_abort) state_next = DRAIN;
            DRAIN:   if (fifo_count == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Run bookkeeping: target latch, attempt/accept counters, reject run-length, abort flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            target      <= '0;
            attempt_cnt <= '0;
            accept_cnt  <= '0;
            reject_len  <= '0;
            aborted     <= 1'b0;
        end else if (start_run) begin
            target      <= num_samples;
            attempt_cnt <= '0;
            accept_cnt  <= '0;
            reject_len  <= '0;
            aborted     <= 1'b0;
        end else if (xfer) begin
            attempt_cnt <= attempt_inc;
            if (bus.in_sat) begin
                accept_cnt <= accept_inc;
                reject_len <= '0;
            end else begin
                reject_len <= reject_len + REJ_W'(1);
                if (hit_abort) aborted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_accept_fifo.sv
// Directed self-checking bench for sample_accept_fifo (DEPTH=4, MAX_REJECT=4).
module tb_sample_accept_fifo;

    localparam int CW         = 16;
    localparam int DEPTH      = 4;
    localparam int CNT_W      = 32;
    localparam int MAX_REJECT = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic [CNT_W-1:0] attempt_cnt;
    logic [CNT_W-1:0] accept_cnt;
    logic             busy;
    logic             done;
    logic             aborted;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [CW-1:0] got_q[$];

    sample_accept_fifo_if #(.CAND_W(CW)) bus ();

    sample_accept_fifo #(
        .CAND_W     (CW),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W),
        .MAX_REJECT (MAX_REJECT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .bus         (bus.slave),
        .attempt_cnt (attempt_cnt),
        .accept_cnt  (accept_cnt),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe done pulses and delivered samples mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got_q.push_back(bus.out_cand);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n);
        start = 1'b1;
        num_samples = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy === 1'b1 && k < 30) begin
            tick();
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle_timeout: busy=%b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_cand !== '0) begin n_err++; $display("FAIL rst_out_cand: got %h want 0", bus.out_cand); end
        n_cmp++; if (attempt_cnt !== '0) begin n_err++; $display("FAIL rst_attempt: got %0d want 0", attempt_cnt); end
        n_cmp++; if (accept_cnt !== '0) begin n_err++; $display("FAIL rst_accept: got %0d want 0", accept_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (aborted !== 1'b0) begin n_err++; $display("FAIL rst_aborted: got %b want 0", aborted); end
    endtask

    task automatic test_basic();
        logic [4:0] pat = 5'b11010;
        logic [CW-1:0] exp_q[3] = '{16'd101, 16'd103, 16'd104};
        int d0 = done_cnt;
        got_q.delete();
        bus.out_ready = 1'b1;
        do_start(3);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sat = pat[i];
            bus.in_cand = CW'(100 + i);
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (attempt_cnt !== 32'd5) begin n_err++; $display("FAIL basic_attempt: got %0d want 5", attempt_cnt); end
        n_cmp++; if (accept_cnt !== 32'd3) begin n_err++; $display("FAIL basic_accept: got %0d want 3", accept_cnt); end
        wait_idle("basic");
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (aborted !== 1'b0) begin n_err++; $display("FAIL basic_aborted: got %b want 0", aborted); end
        n_cmp++; if (got_q.size() != 3) begin n_err++; $display("FAIL basic_out_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [CW-1:0] v = (i < got_q.size()) ? got_q[i] : 'x;
            n_cmp++; if (v !== exp_q[i]) begin n_err++; $display("FAIL basic_out_cand[%0d]: got %0d want %0d", i, v, exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        got_q.delete();
        bus.out_ready = 1'b0;
        do_start(10);
        bus.in_valid = 1'b1;
        bus.in_sat = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_cand = CW'(200 + k);
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_fill_ready[%0d]: got %b want 1", k, bus.in_ready); end
            tick();
        end
        bus.in_cand = CW'(204);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", bus.in_ready); end
        tick();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.out_cand !== CW'(200)) begin n_err++; $display("FAIL bp_hold_head: got %0d want 200", bus.out_cand); end
        n_cmp++; if (attempt_cnt !== 32'd4) begin n_err++; $display("FAIL bp_hold_attempt: got %0d want 4", attempt_cnt); end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_reassert_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_cand !== CW'(201)) begin n_err++; $display("FAIL bp_next_head: got %0d want 201", bus.out_cand); end
        for (int k = 4; k < 10; k++) begin
            bus.in_cand = CW'(200 + k);
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_stream_ready[%0d]: got %b want 1", k, bus.in_ready); end
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (accept_cnt !== 32'd10) begin n_err++; $display("FAIL bp_accept: got %0d want 10", accept_cnt); end
        wait_idle("bp");
        n_cmp++; if (got_q.size() != 10) begin n_err++; $display("FAIL bp_out_count: got %0d want 10", got_q.size()); end
        for (int i = 0; i < 10; i++) begin
            logic [CW-1:0] v = (i < got_q.size()) ? got_q[i] : 'x;
            n_cmp++; if (v !== CW'(200 + i)) begin n_err++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, v, 200 + i); end
        end
    endtask

    task automatic test_abort();
        int d0 = done_cnt;
        got_q.delete();
        bus.out_ready = 1'b1;
        do_start(5);
        bus.in_valid = 1'b1;
        bus.in_sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_cand = CW'(500 + i);
            n_cmp++; if (aborted !== 1'b0) begin n_err++; $display("FAIL abort_early[%0d]: got %b want 0", i, aborted); end
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (aborted !== 1'b1) begin n_err++; $display("FAIL abort_flag: got %b want 1", aborted); end
        n_cmp++; if (attempt_cnt !== 32'd4) begin n_err++; $display("FAIL abort_attempt: got %0d want 4", attempt_cnt); end
        n_cmp++; if (accept_cnt !== 32'd0) begin n_err++; $display("FAIL abort_accept: got %0d want 0", accept_cnt); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL abort_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy: got %b want 1", busy); end
        wait_idle("abort");
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL abort_done_pulses: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL abort_out_count: got %0d want 0", got_q.size()); end
        repeat (3) tick();
        n_cmp++; if (aborted !== 1'b1) begin n_err++; $display("FAIL abort_sticky: got %b want 1", aborted); end
    endtask

    task automatic test_zero();
        int d0 = done_cnt;
        bit seen = 0;
        got_q.delete();
        bus.in_valid = 1'b1;
        bus.in_sat = 1'b1;
        bus.in_cand = CW'(600);
        do_start(0);
        n_cmp++; if (aborted !== 1'b0) begin n_err++; $display("FAIL zero_aborted_clear: got %b want 0", aborted); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL zero_in_ready: got %b want 0", bus.in_ready); end
        for (int k = 0; k < 3 && !seen; k++) begin
            tick();
            if (done === 1'b1) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL zero_done_timing: got no done want done within 3 cycles"); end
        bus.in_valid = 1'b0;
        wait_idle("zero");
        n_cmp++; if (attempt_cnt !== '0) begin n_err++; $display("FAIL zero_attempt: got %0d want 0", attempt_cnt); end
        n_cmp++; if (accept_cnt !== '0) begin n_err++; $display("FAIL zero_accept: got %0d want 0", accept_cnt); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL zero_out_count: got %0d want 0", got_q.size()); end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt;
        got_q.delete();
        bus.out_ready = 1'b0;
        do_start(5);
        bus.in_valid = 1'b1;
        bus.in_sat = 1'b1;
        bus.in_cand = CW'(300);
        tick();
        bus.in_cand = CW'(301);
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (accept_cnt !== 32'd2) begin n_err++; $display("FAIL rmid_pre_accept: got %0d want 2", accept_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_cand !== '0) begin n_err++; $display("FAIL rmid_out_cand: got %0d want 0", bus.out_cand); end
        n_cmp++; if (attempt_cnt !== '0) begin n_err++; $display("FAIL rmid_attempt: got %0d want 0", attempt_cnt); end
        n_cmp++; if (accept_cnt !== '0) begin n_err++; $display("FAIL rmid_accept: got %0d want 0", accept_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_in_ready: got %b want 0", bus.in_ready); end
        repeat (4) tick();
        n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_cnt - d0); end
        bus.out_ready = 1'b1;
        do_start(1);
        bus.in_valid = 1'b1;
        bus.in_cand = CW'(310);
        tick();
        bus.in_valid = 1'b0;
        wait_idle("rmid_fresh");
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL rmid_fresh_done: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== CW'(310)) begin n_err++; $display("FAIL rmid_fresh_out: got size %0d want one sample 310", got_q.size()); end
    endtask

    task automatic test_start_ignored();
        got_q.delete();
        bus.out_ready = 1'b1;
        do_start(2);
        bus.in_valid = 1'b1;
        bus.in_sat = 1'b1;
        bus.in_cand = CW'(400);
        tick();
        bus.in_valid = 1'b0;
        start = 1'b1;
        num_samples = 32'd5;
        tick();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_busy: got %b want 1", busy); end
        n_cmp++; if (attempt_cnt !== 32'd1) begin n_err++; $display("FAIL ign_attempt: got %0d want 1", attempt_cnt); end
        n_cmp++; if (accept_cnt !== 32'd1) begin n_err++; $display("FAIL ign_accept: got %0d want 1", accept_cnt); end
        bus.in_valid = 1'b1;
        bus.in_cand = CW'(401);
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL ign_target_reached: in_ready=%b want 0", bus.in_ready); end
        wait_idle("ign");
        n_cmp++; if (accept_cnt !== 32'd2) begin n_err++; $display("FAIL ign_final_accept: got %0d want 2", accept_cnt); end
        n_cmp++; if (got_q.size() != 2 || got_q[0] !== CW'(400) || got_q[1] !== CW'(401)) begin n_err++; $display("FAIL ign_out: got size %0d want 400,401", got_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_samples = '0;
        bus.in_valid = 1'b0;
        bus.in_cand = '0;
        bus.in_sat = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_zero();
        test_reset_mid();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sample_accept_fifo.md
Name: sample_accept_fifo

Overview:
- Stage directly downstream of the combinational constraint checker.
- Each cycle it takes one packed candidate together with the checker's satisfied bit `sat`.
- Satisfied candidates go into a FIFO, rejected ones are dropped, and attempts and acceptances are counted.
- A run stops after N accepted samples, or aborts after too many consecutive rejects; the FIFO is then drained to the sample sink.

Parameters:
- CAND_W, 779: packed candidate width (concatenation of the 20 checker variables, var_19 at MSB, var_0 at LSB).
- DEPTH, 8: FIFO entries; power of two, >=2.
- CNT_W, 32: width of attempt/accept counters and num_samples.
- MAX_REJECT, 1024: consecutive rejects that trigger abort; must be >=1.

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: one-cycle pulse; begins a run; honoured only in IDLE.
- num_samples, in, CNT_W: target accepts; sampled on start.
- in_valid, in, 1: candidate and sat are valid.
- in_ready, out, 1: stage consumes the candidate this cycle.
- in_cand, in, CAND_W: candidate vector.
- in_sat, in, 1: checker result (1 = all constraints hold).
- out_valid, out, 1: FIFO head is valid.
- out_ready, in, 1: sink accepts head.
- out_cand, out, CAND_W: FIFO head data.
- attempt_cnt, out, CNT_W: candidates consumed this run.
- accept_cnt, out, CNT_W: candidates pushed this run.
- busy, out, 1: state != IDLE.
- done, out, 1: one-cycle pulse at end of run.
- aborted, out, 1: sticky; set on reject abort; cleared on next start.

Behaviour:
- Reset values:
  - in_ready=0, out_valid=0, out_cand=0, attempt_cnt=0, accept_cnt=0, busy=0, done=0, aborted=0.
  - FIFO empty, state IDLE, reject run-length=0, target register=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start, latch num_samples, clear both counters, the reject run-length and aborted.
  - If num_samples==0, go to DRAIN; otherwise go to RUN.
- RUN:
  - in_ready = !fifo_full, combinational from registered state only; it does not depend on out_ready.
  - A transfer happens when in_valid & in_ready. Each transfer increments attempt_cnt.
  - sat=1: push in_cand, increment accept_cnt, clear the reject run-length.
  - sat=0: drop the candidate, increment the run-length.
  - When the accept that makes accept_cnt==target is transferred, go to DRAIN the next cycle.
  - When the run-length reaches MAX_REJECT, set aborted and go to DRAIN.
- DRAIN: in_ready=0; when the FIFO is empty, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- busy is high in RUN, DRAIN and DONE.
- FIFO:
  - Registered, first-word-fall-through. A candidate accepted at edge k appears on out_valid/out_cand after edge k (one cycle latency).
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle leave occupancy unchanged; with one entry, the new entry becomes the head.
  - out_cand is held stable while out_valid & !out_ready.
  - The FIFO keeps popping in every state, including IDLE.
- Pointers: log2(DEPTH)-bit with a separate occupancy counter (0..DEPTH); full = count==DEPTH.
- Counters saturate at all-ones and never wrap. A saturated attempt_cnt does not block accepts.
- start outside IDLE is ignored. start and rst in the same cycle: rst wins.
- Reset mid-run: FIFO contents discarded, no done pulse, all outputs return to their reset values the following cycle.

Decomposition:
- Shared package `sampler_pkg`:
  - Typedef `cand_t`, logic [CAND_W-1:0].
  - Enum `acc_state_e` {IDLE, RUN, DRAIN, DONE}.
  - Default constants CAND_W_DEF=779, CNT_W_DEF=32.
- One sub-module: `sync_fifo_fwft` (generic DATA_W/DEPTH, push/pop/full/empty/count). It is reused by other sampler stages.

Test Plan:
1. num_samples=3, DEPTH=8, out_ready=1, stream sat=0,1,0,1,1 with in_valid=1 -> after the 5th transfer: attempt_cnt=5, accept_cnt=3. out_cand shows the three sat candidates in order. done pulses once, aborted=0, busy returns to 0.
2. num_samples=10, DEPTH=4, out_ready=0, all sat=1 -> in_ready drops after 4 transfers. With out_ready=1, one item pops per cycle and in_ready reasserts in the cycle after the first pop; order is preserved.
3. MAX_REJECT=4, num_samples=5, sat=0 always -> after the 4th reject aborted=1, attempt_cnt=4, accept_cnt=0, DRAIN then DONE, done pulses. aborted stays 1 until the next start.
4. num_samples=0 -> no transfers, done pulses within 3 cycles of start, counters=0.
5. rst asserted mid-RUN with 2 entries queued -> next cycle out_valid=0, counters=0, busy=0, no done pulse. A fresh start runs normally.
6. start pulsed while in RUN -> ignored; num_samples latched at the original start is still the target.
